// File: rtl/tdc_stats_pkg.sv
// tdc_stats_pkg
//   Shared types and defaults for the TDC window statistics engine.
//   - state_e   : control FSM states
//   - rd_sel_e  : readout mux select encodings
//   - DefaultCodeW / DefaultLog2NMax : default parameter values
//   - clamp_n_log2 : limits a requested window exponent to the supported maximum
package tdc_stats_pkg;

    localparam int unsigned DefaultCodeW    = 8;
    localparam int unsigned DefaultLog2NMax = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StCalc  = 2'd2,
        StDone  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SelMean   = 2'd0,
        SelMin    = 2'd1,
        SelMax    = 2'd2,
        SelStatus = 2'd3
    } rd_sel_e;

    function automatic logic [2:0] clamp_n_log2(input logic [2:0] n, input logic [2:0] lim);
        return (n > lim) ? lim : n;
    endfunction

endpackage

// File: rtl/tdc_stats_datapath.sv
// tdc_stats_datapath
//   Accumulation datapath for one statistics window: running sum, sample count,
//   running min/max and the mean computed by a right shift of the sum.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   clear          : start of a new window (clears sum/cnt, min=all-ones, max=0)
//   sample         : accept tdc_code into the window this cycle
//   calc           : capture mean = sum >> n_log2_lat
//   n_log2_lat     : latched, already-clamped window exponent
//   tdc_code       : incoming TDC code
//   last_sample    : the sample accepted this cycle completes the window
//   mean/code_min/code_max : result registers
module tdc_stats_datapath
    import tdc_stats_pkg::*;
#(
    parameter int unsigned CODE_W     = DefaultCodeW,
    parameter int unsigned LOG2_N_MAX = DefaultLog2NMax
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sample,
    input  logic              calc,
    input  logic [2:0]        n_log2_lat,
    input  logic [CODE_W-1:0] tdc_code,
    output logic              last_sample,
    output logic [CODE_W-1:0] mean,
    output logic [CODE_W-1:0] code_min,
    output logic [CODE_W-1:0] code_max
);

    localparam int unsigned SumW = CODE_W + LOG2_N_MAX;
    localparam int unsigned CntW = LOG2_N_MAX + 1;

    logic [SumW-1:0]   sum_q;
    logic [CntW-1:0]   cnt_q;
    logic [CODE_W-1:0] mean_q;
    logic [CODE_W-1:0] min_q;
    logic [CODE_W-1:0] max_q;

    logic [CntW-1:0]   win_n;
    logic [CntW-1:0]   cnt_inc;
    logic [SumW-1:0]   sum_shifted;

    // n_log2_lat never exceeds LOG2_N_MAX, so N fits in CntW bits.
    assign win_n       = CntW'(1) << n_log2_lat;
    assign cnt_inc     = cnt_q + CntW'(1);
    assign last_sample = sample && (cnt_inc == win_n);
    // Truncating shift: integer mean, rounded toward zero.
    assign sum_shifted = sum_q >> n_log2_lat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cnt_q  <= '0;
            mean_q <= '0;
            min_q  <= '0;
            max_q  <= '0;
        end else if (clear) begin
            sum_q <= '0;
            cnt_q <= '0;
            min_q <= '1;
            max_q <= '0;
        end else begin
            if (sample) begin
                sum_q <= sum_q + SumW'(tdc_code);
                cnt_q <= cnt_inc;
                if (tdc_code < min_q) begin
                    min_q <= tdc_code;
                end
                if (tdc_code > max_q) begin
                    max_q <= tdc_code;
                end
            end
            if (calc) begin
                mean_q <= sum_shifted[CODE_W-1:0];
            end
        end
    end

    assign mean     = mean_q;
    assign code_min = min_q;
    assign code_max = max_q;

endmodule

// File: rtl/tdc_window_stats.sv
// tdc_window_stats
//   Windowed statistics engine for the TDC code stream. Collects 2^n_log2
//   samples, then reports mean/min/max through a registered byte readout.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   tdc_code   : TDC output code (clk domain)
//   tdc_valid  : one-cycle strobe marking a new tdc_code
//   start      : begin a new window (honoured in IDLE and DONE only)
//   n_log2     : window exponent, latched and clamped at start
//   rd_sel     : 0 mean, 1 min, 2 max, 3 status {busy, done, 000, n_log2_lat}
//   rd_data    : registered readout byte, one cycle behind rd_sel
//   busy       : window collecting or computing
//   done       : results stable
module tdc_window_stats
    import tdc_stats_pkg::*;
#(
    parameter int unsigned CODE_W     = DefaultCodeW,
    parameter int unsigned LOG2_N_MAX = DefaultLog2NMax
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] tdc_code,
    input  logic              tdc_valid,
    input  logic              start,
    input  logic [2:0]        n_log2,
    input  logic [1:0]        rd_sel,
    output logic [CODE_W-1:0] rd_data,
    output logic              busy,
    output logic              done
);

    state_e            state_q;
    logic [2:0]        n_lat_q;
    logic              busy_q;
    logic              done_q;
    logic [CODE_W-1:0] rd_data_q;
    logic [CODE_W-1:0] rd_mux;
    logic [CODE_W-1:0] status;

    logic              clear;
    logic              sample;
    logic              calc;
    logic              last_sample;
    logic [CODE_W-1:0] mean;
    logic [CODE_W-1:0] code_min;
    logic [CODE_W-1:0] code_max;

    logic              start_ok;

    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    assign clear    = start_ok;
    assign sample   = (state_q == StAccum) && tdc_valid;
    assign calc     = (state_q == StCalc);

    tdc_stats_datapath #(
        .CODE_W     (CODE_W),
        .LOG2_N_MAX (LOG2_N_MAX)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .sample      (sample),
        .calc        (calc),
        .n_log2_lat  (n_lat_q),
        .tdc_code    (tdc_code),
        .last_sample (last_sample),
        .mean        (mean),
        .code_min    (code_min),
        .code_max    (code_max)
    );

    // busy/done are a registered decode of the state, so they trail it by one
    // cycle; done additionally drops on the restart edge so it never overlaps
    // with a fresh window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            n_lat_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= (state_q == StAccum) || (state_q == StCalc);
            done_q <= (state_q == StDone) && !start;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StAccum;
                        n_lat_q <= clamp_n_log2(n_log2, 3'(LOG2_N_MAX));
                    end
                end
                StAccum: begin
                    if (last_sample) begin
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    state_q <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        status                = '0;
        status[CODE_W-1]      = busy_q;
        status[CODE_W-2]      = done_q;
        status[2:0]           = n_lat_q;
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel_e'(rd_sel))
            SelMean:   rd_mux = mean;
            SelMin:    rd_mux = code_min;
            SelMax:    rd_mux = code_max;
            SelStatus: rd_mux = status;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_mux;
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/tdc_window_stats.md
# tdc_window_stats

Windowed statistics engine downstream of the TDC stage. It consumes the 8-bit TDC code stream, accumulates a power-of-two window of samples, and produces mean, minimum and maximum codes. Results are read back one byte at a time through a registered readout mux, which fits the container's 8-bit dedicated output path. It lets the chip report delay-line statistics without an external logic analyser capturing every TDC sample.

## Interface
Parameters:
- CODE_W, 8, width of a TDC code and of every result byte
- LOG2_N_MAX, 4, largest window exponent; window N = 2^n_log2 ≤ 2^LOG2_N_MAX
- SUM_W, CODE_W+LOG2_N_MAX, accumulator width (derived; not overridden)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- tdc_code  in  CODE_W  TDC output code, already in clk domain
- tdc_valid  in  1  one-cycle strobe: tdc_code is a new sample
- start  in  1  begin a new window (level sampled each cycle)
- n_log2  in  3  window exponent, latched at start; values > LOG2_N_MAX clamp to LOG2_N_MAX
- rd_sel  in  2  readout select: 0 mean, 1 min, 2 max, 3 status
- rd_data  out  CODE_W  registered readout byte
- busy  out  1  high in ACCUM and CALC
- done  out  1  high in DONE (results stable)

## Operation
- Reset (rst_n low at a clk edge) sets the FSM to IDLE, clears sum, cnt, mean, and the latched exponent, sets min to 0x00 and max to 0x00, and drives rd_data=0x00, busy=0 and done=0. Reset in any state, including mid-window, discards the partial window.
- FSM states: IDLE, ACCUM, CALC, DONE.
- IDLE: on start=1 → ACCUM. That edge latches the clamped n_log2, clears sum and cnt, and sets min=all-ones and max=0.
- ACCUM: on each tdc_valid=1:
  - sum += tdc_code (zero-extended to SUM_W)
  - min = min(min, tdc_code)
  - max = max(max, tdc_code)
  - cnt += 1
  - When the sample taken makes cnt == N → CALC. start is ignored in ACCUM.
- CALC: a single cycle. mean = sum >> n_log2_latched, truncated toward zero, low CODE_W bits. Then → DONE.
- DONE: results are held. start=1 → ACCUM with the same initialisation as from IDLE. done drops in the same edge.
- Readout: rd_data <= mux(rd_sel) every cycle.
  - rd_sel 0 selects mean, 1 selects min, 2 selects max.
  - rd_sel 3 selects status = {busy, done, 3'b000, n_log2_latched}.
- Readout is valid in every state. Outside DONE it shows live or partial values.
- Width rules: the sum cannot overflow, since N·(2^CODE_W−1) < 2^SUM_W. cnt is LOG2_N_MAX+1 bits wide.

## Timing
- A start asserted at edge k puts the FSM in ACCUM from k+1. A tdc_valid coincident with the start edge is not counted.
- A tdc_valid coinciding with the last sample is accumulated. CALC follows on the next cycle, and done=1 appears two edges after the last sample edge.
- With tdc_valid held continuously, window latency from start is N+2 cycles to done.
- rd_data lags rd_sel by one cycle.
- busy and done are registered outputs decoded from the state. They are never high together.
- n_log2 changes outside the start edge have no effect on a window in progress.

## Structure
- Package tdc_stats_pkg holds the state enum (IDLE/ACCUM/CALC/DONE), the rd_sel encodings (SEL_MEAN/SEL_MIN/SEL_MAX/SEL_STATUS), and the CODE_W and LOG2_N_MAX defaults.
- There is one natural sub-module, tdc_stats_datapath: the sum/min/max/cnt registers and the mean shift. It is controlled by the FSM in the top, which also holds the readout mux register.
- Instantiated in the container with tdc_code from the TDC output. Its rd_data feeds a spare uo_out mux leg.

## Test plan
- Reset, then idle with rd_sel swept 0..3 → rd_data 0x00,0x00,0x00,0x00; busy=0, done=0.
- n_log2=2, start, then valid codes 10,20,30,40 back-to-back → done at cycle 6 after start; mean 25, min 10, max 40; status 0x42.
- n_log2=7 (clamped to 4), 16 samples of 0xFF → mean 0xFF, min=max 0xFF; status low bits = 4.
- tdc_valid coincident with start (code 0x00), then 0x80,0x80 with n_log2=1 → mean 0x80, min 0x80 (the coincident sample is ignored).
- n_log2=2, rst_n low after 2 of 4 samples, then release → all outputs 0x00, state IDLE; a new start yields a correct fresh result.
- In DONE, start with n_log2=0 and one sample 0x05 → done drops on the start edge, then rises with mean=min=max=0x05. A start pulsed during ACCUM is ignored, with no restart and no change to cnt.
